// File: rtl/csr_reg_bank.sv
// CSR bank behind the APB bridge: decodes single-cycle register requests, answers after a
// fixed latency, and exposes RW registers to the core while RO slots mirror hw_status.
module csr_reg_bank #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 11,
    parameter int                    NUM_REGS    = 8,
    parameter int                    RESP_LAT    = 1,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = NUM_REGS'(8'h80),
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           bus_req_i,
    input  logic                           bus_req_is_wr_i,
    input  logic [ADDR_WIDTH-1:0]          bus_addr_i,
    input  logic [DATA_WIDTH-1:0]          bus_wr_data_i,
    input  logic [DATA_WIDTH-1:0]          bus_wr_biten_i,
    output logic                           bus_ready_o,
    output logic                           bus_err_o,
    output logic [DATA_WIDTH-1:0]          bus_rd_data_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] hw_ctrl_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status_i,
    output logic [NUM_REGS-1:0]            hw_wr_pulse_o
);

    localparam int                IDX_W    = ADDR_WIDTH - 2;
    localparam int                CNT_W    = 3;
    localparam logic [IDX_W:0]    IDX_LIM  = (IDX_W + 1)'(NUM_REGS);
    localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(RESP_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    pend_err_q;
    logic [DATA_WIDTH-1:0]   pend_data_q;
    logic                    ready_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [NUM_REGS-1:0]     wr_pulse_q;
    logic [DATA_WIDTH-1:0]   csr_q [NUM_REGS];

    logic [IDX_W-1:0]        req_idx;
    logic                    req_in_range;
    logic                    req_ro;
    logic                    req_err;
    logic                    req_wr_ok;
    logic [DATA_WIDTH-1:0]   req_rd_val;
    logic [DATA_WIDTH-1:0]   rd_capture_d;

    // Index match is done per slot so out-of-range addresses never index past the array.
    always_comb begin
        req_idx      = bus_addr_i[ADDR_WIDTH-1:2];
        req_in_range = ({1'b0, req_idx} < IDX_LIM);
        req_ro       = 1'b0;
        req_rd_val   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (req_idx == IDX_W'(i)) begin
                req_ro     = RO_MASK[i];
                req_rd_val = RO_MASK[i] ? hw_status_i[i*DATA_WIDTH +: DATA_WIDTH] : csr_q[i];
            end
        end
        req_err      = (bus_addr_i[1:0] != 2'b00) | ~req_in_range | (bus_req_is_wr_i & req_ro);
        req_wr_ok    = bus_req_is_wr_i & ~req_err;
        rd_capture_d = (bus_req_is_wr_i | req_err) ? '0 : req_rd_val;
        cnt_d        = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_err_q  <= 1'b0;
            pend_data_q <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            wr_pulse_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                csr_q[i] <= RESET_VALUE;
            end
        end else begin
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            wr_pulse_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_req_i) begin
                        pend_err_q  <= req_err;
                        pend_data_q <= rd_capture_d;
                        if (req_wr_ok) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (req_idx == IDX_W'(i)) begin
                                    csr_q[i]      <= (csr_q[i] & ~bus_wr_biten_i)
                                                   | (bus_wr_data_i & bus_wr_biten_i);
                                    wr_pulse_q[i] <= 1'b1;
                                end
                            end
                        end
                        // A single-cycle latency skips WAIT and answers straight away.
                        if (RESP_LAT == 1) begin
                            state_q   <= ST_RESP;
                            ready_q   <= 1'b1;
                            err_q     <= req_err;
                            rd_data_q <= rd_capture_d;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= LAT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q   <= ST_RESP;
                        ready_q   <= 1'b1;
                        err_q     <= pend_err_q;
                        rd_data_q <= pend_data_q;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
        assign hw_ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : csr_q[g];
    end

    assign bus_ready_o   = ready_q;
    assign bus_err_o     = err_q;
    assign bus_rd_data_o = rd_data_q;
    assign hw_wr_pulse_o = wr_pulse_q;

endmodule
